// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, writer, memory and statistics signals of vram_arbiter
// slave modport: the arbiter side (takes requests and mem_rdata, drives grants, mem command, stats)
// master modport: the surrounding system side (timing generator, writers, memory)
interface vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic de;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic disp_rvalid;
  logic wr0_valid;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic wr0_ready;
  logic wr1_valid;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic wr1_ready;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic stat_clr;
  logic [15:0] stat_wr_cnt;
  modport slave (
    input de, disp_addr, wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data, mem_rdata, stat_clr,
    output disp_rdata, disp_rvalid, wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata, stat_wr_cnt
  );
  modport master (
    output de, disp_addr, wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data, mem_rdata, stat_clr,
    input disp_rdata, disp_rvalid, wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata, stat_wr_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, display reads first, two round-robin writers
// pix_clk/rst_pix: pixel clock and synchronous active-high reset
// bus (slave): de/disp_* display read, wr0_*/wr1_* writer handshakes, mem_* memory command, stat_* write counter
module vram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input logic pix_clk,
  input logic rst_pix,
  vram_arbiter_if.slave bus
);
  logic last_grant, rvalid, gnt0, gnt1, fire;
  logic [15:0] cnt;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  // last_grant=1 hands priority to writer 0 and vice versa
  always_comb begin
    gnt0 = !rst_pix && !bus.de && bus.wr0_valid && (!bus.wr1_valid || last_grant);
    gnt1 = !rst_pix && !bus.de && bus.wr1_valid && (!bus.wr0_valid || !last_grant);
    fire = gnt0 || gnt1;
    waddr = gnt1 ? bus.wr1_addr : bus.wr0_addr;
    wdata = gnt1 ? bus.wr1_data : bus.wr0_data;
  end
  assign bus.wr0_ready = gnt0;
  assign bus.wr1_ready = gnt1;
  assign bus.mem_en = !rst_pix && (bus.de || fire);
  assign bus.mem_we = fire;
  assign bus.mem_addr = bus.de ? bus.disp_addr : waddr;
  assign bus.mem_wdata = wdata;
  assign bus.disp_rvalid = rvalid;
  assign bus.disp_rdata = rvalid ? bus.mem_rdata : '0;
  assign bus.stat_wr_cnt = cnt;
  always_ff @(posedge pix_clk) begin
    if (rst_pix) begin
      last_grant <= 1'b1;
      rvalid <= 1'b0;
      cnt <= '0;
    end else begin
      rvalid <= bus.de;
      if (fire) last_grant <= gnt1;
      cnt <= bus.stat_clr ? '0 : (fire && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    end
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 4, giving the pixel data width.

Interface
REQ-003 The block SHALL have port pix_clk, input, 1 bit: the single pixel clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_pix, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port de, input, 1 bit: display-enable from the display timing generator.
REQ-006 The block SHALL have port disp_addr, input, ADDR_W bits: display read address.
REQ-007 The block SHALL have port disp_rdata, output, DATA_W bits: display read data.
REQ-008 The block SHALL have port disp_rvalid, output, 1 bit: disp_rdata valid.
REQ-009 The block SHALL have ports wr0_valid (input, 1), wr0_addr (input, ADDR_W), wr0_data (input, DATA_W) and wr0_ready (output, 1): writer 0 request channel.
REQ-010 The block SHALL have ports wr1_valid (input, 1), wr1_addr (input, ADDR_W), wr1_data (input, DATA_W) and wr1_ready (output, 1): writer 1 request channel.
REQ-011 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): single-port memory command.
REQ-012 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid one cycle after a read command.
REQ-013 The block SHALL have port stat_clr, input, 1 bit: clear the statistics counter.
REQ-014 The block SHALL have port stat_wr_cnt, output, 16 bits: count of accepted writes.

Function
REQ-015 The display read SHALL have absolute priority: when de=1, the block SHALL drive mem_en=1, mem_we=0 and mem_addr=disp_addr in the same cycle, with wr0_ready=wr1_ready=0.
REQ-016 When de=0, the block SHALL grant at most one writer per cycle; wrN_ready SHALL be asserted only for the granted writer, and only when wrN_valid=1.
REQ-017 On a grant, the block SHALL drive mem_en=1, mem_we=1, and mem_addr/mem_wdata from the granted writer, combinationally in the same cycle; the transfer completes when valid and ready are both 1.
REQ-018 Writer arbitration SHALL be round-robin, using a 1-bit registered pointer last_grant that indicates which writer has priority next.
REQ-019 With both writers valid, the writer other than last_grant SHALL win, and last_grant SHALL update to the winner at the clock edge.
REQ-020 With one writer valid, that writer SHALL win and last_grant SHALL update to it.
REQ-021 With no writer valid and de=0, the block SHALL drive mem_en=0 and mem_we=0, and last_grant SHALL hold.
REQ-022 last_grant SHALL NOT change in any cycle with de=1.
REQ-023 A writer held off by de SHALL keep its request pending; the block SHALL place no requirement on the writer beyond holding valid, addr and data stable until ready.
REQ-024 disp_rvalid SHALL be de delayed by exactly 1 cycle through a register.
REQ-025 disp_rdata SHALL equal mem_rdata whenever disp_rvalid=1, and SHALL be 0 whenever disp_rvalid=0.
REQ-026 stat_wr_cnt SHALL increment by 1 on each completed write, saturating at 16'hFFFF.
REQ-027 When stat_clr=1, stat_wr_cnt SHALL be set to 0 at the clock edge; a write completed in the same cycle SHALL NOT be counted.
REQ-028 A de rising edge SHALL take the memory in that same cycle; a write presented in that cycle SHALL stall with ready=0 and SHALL NOT be lost or duplicated.
REQ-029 The block SHALL have no combinational path from mem_rdata to any output other than disp_rdata.

Reset
REQ-030 While rst_pix=1, the block SHALL hold last_grant=1, so that writer 0 wins the first contention after reset.
REQ-031 While rst_pix=1, the block SHALL hold disp_rvalid=0 and stat_wr_cnt=0.
REQ-032 While rst_pix=1, the block SHALL drive wr0_ready=0, wr1_ready=0, mem_en=0 and mem_we=0, regardless of de or valid inputs.
REQ-033 A reset asserted mid-transfer SHALL abort that transfer with no memory write and no count increment; the writer SHALL re-present it after reset.

Verification
REQ-034 The bench SHALL cover: de=1, disp_addr=0x123, wr0_valid=1 -> mem_en=1, mem_we=0, mem_addr=0x123, wr0_ready=0, and disp_rvalid=1 on the next cycle.
REQ-035 The bench SHALL cover: de=0 with both writers valid for 4 cycles after reset -> grants in order 0,1,0,1, and stat_wr_cnt=4.
REQ-036 The bench SHALL cover: wr1_valid=1 alone with de=0, addr=0x010, data=0x7 -> mem_we=1, mem_addr=0x010, mem_wdata=0x7, wr1_ready=1, and last_grant=1 afterwards.
REQ-037 The bench SHALL cover: de rising in the same cycle wr0_valid rises -> wr0_ready=0 throughout the active period, and the write is granted in the first de=0 cycle with the count incremented exactly once.
REQ-038 The bench SHALL cover: stat_wr_cnt preloaded to 0xFFFE, then 3 writes -> 0xFFFF; then stat_clr=1 together with a write -> stat_wr_cnt=0.
REQ-039 The bench SHALL cover: rst_pix=1 asserted while wr0 is granted -> mem_we=0 in that cycle, stat_wr_cnt=0, and a both-valid request after reset grants writer 0.
